ltc5548_sys_pio_pulse_out: RTL
==============================

// Module: ltc5548_sys_pio_pulse_out
// PURPOSE
//  Avalon-MM slave output PIO, the drive-side counterpart of the system's edge-capturing input PIO.
//  Holds a static output word and generates one-shot, counted pulses (bit inversions) on selected bits.
//  Raises a completion interrupt to the Nios II.
//  Sits on the ltc5548_sys fabric and drives board control lines for the LTC5548 front end.
// PARAMETERS
//  DATA_WIDTH     8       output port width (1..16)
//  RESET_VALUE    0       out_port / data register value after reset
//  DEFAULT_WIDTH  16      pulse-width register value after reset, in clk cycles
//  CNT_WIDTH      16      pulse counter / width register width
// PORTS
//  clk         in   1           system clock, all logic rising-edge
//  reset_n     in   1           asynchronous active-low reset
//  address     in   2           word address of the register
//  chipselect  in   1           slave select
//  write_n     in   1           active-low write strobe, qualified by chipselect
//  writedata   in   32          write data
//  readdata    out  32          registered read data; fixed one-cycle read latency, no waitrequest
//  out_port    out  DATA_WIDTH  pin outputs
//  irq         out  1           level interrupt, = done & irq_en
// BEHAVIOUR
//  Write strobe: wr = chipselect & ~write_n.
//  readdata:
//   - Loaded every clock from the address mux; the chipselect state is ignored for reads.
//   - Reset value is 0.
//   - Unused bits read 0.
//  addr0 DATA: rw; data_reg <= writedata[DATA_WIDTH-1:0]; reset value RESET_VALUE.
//  addr1 CFG: rw; [CNT_WIDTH-1:0] = width, reset DEFAULT_WIDTH; [31] = irq_en, reset 0.
//  addr2 TRIG:
//   - Write: writedata[DATA_WIDTH-1:0] is the pulse mask.
//   - Read: {cnt in [31:16], mask in [15:0]}.
//  addr3 STAT:
//   - Read: [0] done, [1] overrun, [2] busy.
//   - Write 1 to clear: writedata[0] clears done, writedata[1] clears overrun; busy is read-only.
//  out_port = data_reg ^ (busy ? mask : 0); combinational from flops only, no input paths.
//  Reset values: out_port = RESET_VALUE, irq = 0.
//  FSM states: IDLE, PULSE. Reset state is IDLE, with mask = 0 and cnt = 0.
//   - IDLE + TRIG write with nonzero mask:
//       mask <= mask_wd; cnt <= (width==0) ? 1 : width; -> PULSE.
//       Inverted bits appear on the cycle after the write edge.
//   - IDLE + TRIG write with zero mask: no effect, no flag.
//   - PULSE: cnt decrements each clock.
//       When cnt==1: -> IDLE, mask <= 0, cnt <= 0, done <= 1.
//       Pulse length is exactly max(width,1) clk cycles.
//   - PULSE + TRIG write (any mask): ignored, pulse is unaffected, overrun <= 1.
//  Simultaneous events:
//   - STAT clear and set of the same bit on the same edge: the set wins (flag stays 1).
//   - DATA write during PULSE: data_reg updates immediately; the XOR continues, so masked pins
//     show the inverted new value.
//   - CFG write during PULSE: the current pulse is unaffected; the new width applies to the next trigger.
//  Reset asserted mid-pulse: all state clears asynchronously; out_port = RESET_VALUE immediately,
//  irq = 0, no done flag.
//  Counter arithmetic: unsigned, no wrap. cnt never decrements below 1 while in PULSE.
// TESTING
//  1. Reset, then read all addresses:
//     DATA=0, CFG=0x00000010, STAT=0, irq=0, out_port=0.
//  2. Write DATA=0xA5; CFG=3; TRIG=0x0F:
//     out_port=0xAA for exactly 3 clks, then 0xA5; STAT=0x1.
//  3. Write CFG=0x80000000 (width 0, irq_en 1); TRIG=0x01:
//     1-clk pulse; irq rises; write STAT=1 -> irq=0 next clk.
//  4. Write CFG=100; TRIG=0x01; TRIG=0x02 at cycle 10:
//     pulse stays on bit0 for 100 clks; STAT=0x3 at completion.
//  5. During a 50-clk pulse, write DATA=0xFF at cycle 20:
//     out_port=0xFE until the pulse ends, then 0xFF.
//  6. Deassert reset_n at cycle 5 of a pulse:
//     out_port=0 immediately; after release, STAT=0 and TRIG reads 0.

Source files
------------

// File: rtl/ltc5548_sys_pio_pulse_out_if.sv
// Avalon-MM slave bus bundle for the LTC5548 pulse-out PIO.
// The master drives address and write strobes; the slave returns registered readdata.
interface ltc5548_sys_pio_pulse_out_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ltc5548_sys_pio_pulse_out.sv
// Output PIO for the LTC5548 front-end control lines.
// Holds a static output word and can invert a masked set of bits for a
// programmable number of clocks (one-shot pulse). Completion raises a
// done flag. When enabled, the done flag drives a level interrupt to the Nios II.
module ltc5548_sys_pio_pulse_out #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
  parameter int unsigned           DEFAULT_WIDTH = 16,
  parameter int unsigned           CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ltc5548_sys_pio_pulse_out_if.slave    bus,
  output logic [DATA_WIDTH-1:0]         out_port,
  output logic                          irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] mask_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [CNT_WIDTH-1:0]  width_reg;
  logic                  irq_en_reg;
  logic                  done_reg;
  logic                  overrun_reg;
  logic [31:0]           readdata_reg;

  logic                  wr;
  logic                  wr_data;
  logic                  wr_cfg;
  logic                  wr_trig;
  logic                  wr_stat;
  logic                  busy;
  logic [DATA_WIDTH-1:0] trig_mask;
  logic [15:0]           mask16;
  logic [15:0]           cnt16;
  logic [31:0]           rd_mux;
  logic                  unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr & (bus.address == 2'd0);
  assign wr_cfg    = wr & (bus.address == 2'd1);
  assign wr_trig   = wr & (bus.address == 2'd2);
  assign wr_stat   = wr & (bus.address == 2'd3);
  assign busy      = (state_reg == PULSE);
  assign trig_mask = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  // Per-bit pin drive and zero-extended 16-bit views of mask/cnt for TRIG readback
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
      assign out_port[gi] = data_reg[gi] ^ (busy & mask_reg[gi]);
    end
    for (gi = 0; gi < 16; gi++) begin : g_trig_rd
      if (gi < DATA_WIDTH) begin : g_mask_bit
        assign mask16[gi] = mask_reg[gi];
      end else begin : g_mask_pad
        assign mask16[gi] = 1'b0;
      end
      if (gi < CNT_WIDTH) begin : g_cnt_bit
        assign cnt16[gi] = cnt_reg[gi];
      end else begin : g_cnt_pad
        assign cnt16[gi] = 1'b0;
      end
    end
  endgenerate

  assign irq          = done_reg & irq_en_reg;
  assign bus.readdata = readdata_reg;

  // Software-visible static registers: output word, pulse width and irq enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= RESET_VALUE;
      width_reg  <= CNT_WIDTH'(DEFAULT_WIDTH);
      irq_en_reg <= 1'b0;
    end else begin
      if (wr_data) begin
        data_reg <= bus.writedata[DATA_WIDTH-1:0];
      end
      if (wr_cfg) begin
        width_reg  <= bus.writedata[CNT_WIDTH-1:0];
        irq_en_reg <= bus.writedata[31];
      end
    end
  end

  // Pulse FSM with status flags; flag sets are written after clears so a set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_stat && bus.writedata[0]) begin
        done_reg <= 1'b0;
      end
      if (wr_stat && bus.writedata[1]) begin
        overrun_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (wr_trig && (|trig_mask)) begin
            mask_reg  <= trig_mask;
            cnt_reg   <= (width_reg == '0) ? CNT_ONE : width_reg;
            state_reg <= PULSE;
          end
        end
        PULSE: begin
          if (wr_trig) begin
            overrun_reg <= 1'b1;
          end
          if (cnt_reg == CNT_ONE) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Address decode for reads; unused bits stay zero
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0: rd_mux[DATA_WIDTH-1:0] = data_reg;
      2'd1: begin
        rd_mux[CNT_WIDTH-1:0] = width_reg;
        rd_mux[31]            = irq_en_reg;
      end
      2'd2: rd_mux = {cnt16, mask16};
      2'd3: rd_mux[2:0] = {busy, overrun_reg, done_reg};
      default: rd_mux = '0;
    endcase
  end

  // Read data is registered every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else begin
      readdata_reg <= rd_mux;
    end
  end

endmodule
